// File: rtl/bg_index_fetch_if.sv
// rtl/bg_index_fetch_if.sv - scan-in, ROM and pixel-out signal bundle for bg_index_fetch
interface bg_index_fetch_if #(
    parameter int ADDR_W = 17,
    parameter int IDX_W  = 7
);
    logic [9:0]        h_cnt;
    logic [9:0]        v_cnt;
    logic              valid;
    logic              hsync_in;
    logic              vsync_in;
    logic [3:0]        scroll_step;
    logic [ADDR_W-1:0] rom_addr;
    logic [IDX_W-1:0]  rom_data;
    logic [IDX_W-1:0]  pixel_idx;
    logic              pixel_valid;
    logic              hsync_out;
    logic              vsync_out;

    // Scan generator / ROM / decoder side
    modport master (
        output h_cnt, v_cnt, valid, hsync_in, vsync_in, scroll_step, rom_data,
        input  rom_addr, pixel_idx, pixel_valid, hsync_out, vsync_out
    );

    // bg_index_fetch side
    modport slave (
        input  h_cnt, v_cnt, valid, hsync_in, vsync_in, scroll_step, rom_data,
        output rom_addr, pixel_idx, pixel_valid, hsync_out, vsync_out
    );
endinterface

// File: rtl/bg_index_fetch.sv
// rtl/bg_index_fetch.sv - 2x-upscaled background ROM address gen and index capture, optional BG_SCROLL_EN scrolling
module bg_index_fetch #(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int ADDR_W    = 17,
    parameter int IDX_W     = 7,
    parameter int BLANK_IDX = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    bg_index_fetch_if.slave  bus
);
    logic              q;
    logic [8:0]        x_half;
    logic [8:0]        y_src;
    logic [9:0]        x_src;
    logic [ADDR_W-1:0] addr;

    logic q_d1, hs_d1, vs_d1;
    logic q_d2, hs_d2, vs_d2;

    // The scan counters run into blanking, so valid alone is not trusted
    assign q      = bus.valid && (bus.h_cnt < 10'd640) && (bus.v_cnt < 10'd480);
    assign x_half = bus.h_cnt[9:1];
    assign y_src  = bus.v_cnt[9:1];

    // Only the halved coordinates are used; the LSBs select the duplicated pixel
    logic unused_lsb;
    assign unused_lsb = bus.h_cnt[0] ^ bus.v_cnt[0];

`ifdef BG_SCROLL_EN
    logic [8:0] scroll;
    logic [9:0] scroll_sum;
    logic [9:0] x_sum;
    logic       last_px;

    assign last_px    = bus.valid && (bus.h_cnt == 10'd639) && (bus.v_cnt == 10'd479);
    assign scroll_sum = {1'b0, scroll} + {6'd0, bus.scroll_step};

    // Both operands are below IMG_W, so one subtract is enough to wrap
    assign x_sum = {1'b0, x_half} + {1'b0, scroll};
    assign x_src = (x_sum >= 10'(IMG_W)) ? x_sum - 10'(IMG_W) : x_sum;

    // Advance the scroll offset once per frame, after the last active pixel has used the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scroll <= '0;
        end else if (last_px) begin
            scroll <= (scroll_sum >= 10'(IMG_W)) ? 9'(scroll_sum - 10'(IMG_W)) : scroll_sum[8:0];
        end
    end
`else
    assign x_src = {1'b0, x_half};

    logic unused_step;
    assign unused_step = ^bus.scroll_step;
`endif

    // y*320 as (y<<8)+(y<<6); this shift pair is tied to IMG_W = 320
    assign addr = ADDR_W'({y_src, 8'd0}) + ADDR_W'({y_src, 6'd0}) + ADDR_W'(x_src);

    // Three-stage pipe: address launch, ROM access, index capture, with q and syncs riding alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rom_addr    <= '0;
            q_d1            <= 1'b0;
            hs_d1           <= 1'b1;
            vs_d1           <= 1'b1;
            q_d2            <= 1'b0;
            hs_d2           <= 1'b1;
            vs_d2           <= 1'b1;
            bus.pixel_idx   <= IDX_W'(BLANK_IDX);
            bus.pixel_valid <= 1'b0;
            bus.hsync_out   <= 1'b1;
            bus.vsync_out   <= 1'b1;
        end else begin
            bus.rom_addr    <= q ? addr : '0;
            q_d1            <= q;
            hs_d1           <= bus.hsync_in;
            vs_d1           <= bus.vsync_in;
            q_d2            <= q_d1;
            hs_d2           <= hs_d1;
            vs_d2           <= vs_d1;
            bus.pixel_idx   <= q_d2 ? bus.rom_data : IDX_W'(BLANK_IDX);
            bus.pixel_valid <= q_d2;
            bus.hsync_out   <= hs_d2;
            bus.vsync_out   <= vs_d2;
        end
    end
endmodule

// File: tb/tb_bg_index_fetch.sv
// tb/tb_bg_index_fetch.sv - randomized and directed bench for bg_index_fetch against a frame-level model
module tb_bg_index_fetch;
    localparam int IMG_W = 320;
    localparam int IMG_H = 240;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int BLANK = 6;

    logic clk = 1'b0;
    logic rst_n;

    bg_index_fetch_if #(.ADDR_W(17), .IDX_W(7)) bus ();

    bg_index_fetch #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(17), .IDX_W(7), .BLANK_IDX(BLANK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [6:0] rom [NPIX];

    // Synchronous ROM: data one cycle after the address
    always @(posedge clk) begin
        if (bus.rom_addr < 17'(NPIX))
            bus.rom_data <= rom[bus.rom_addr];
        else
            bus.rom_data <= 7'd0;
    end

    typedef struct {
        int idx;
        bit v;
        bit hs;
        bit vs;
    } pix_t;

    pix_t p [3];
    int   exp_rom;
    int   scroll;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("rom_addr",    32'(bus.rom_addr),    32'(exp_rom));
        chk("pixel_idx",   32'(bus.pixel_idx),   32'(p[2].idx));
        chk("pixel_valid", 32'(bus.pixel_valid), 32'(p[2].v));
        chk("hsync_out",   32'(bus.hsync_out),   32'(p[2].hs));
        chk("vsync_out",   32'(bus.vsync_out),   32'(p[2].vs));
    endtask

    task automatic model_reset();
        pix_t r;
        r.idx = BLANK; r.v = 1'b0; r.hs = 1'b1; r.vs = 1'b1;
        for (int i = 0; i < 3; i++) p[i] = r;
        exp_rom = 0;
        scroll  = 0;
    endtask

    // Called at a falling edge: check outputs, drive one vector, advance the model, wait one cycle
    task automatic apply(input int h, input int v, input bit val, input bit hs, input bit vs,
                         input int stp, input bit rst);
        pix_t e;
        bit   q;
        int   a;
        check_all();
        bus.h_cnt       = 10'(h);
        bus.v_cnt       = 10'(v);
        bus.valid       = val;
        bus.hsync_in    = hs;
        bus.vsync_in    = vs;
        bus.scroll_step = 4'(stp);
        rst_n           = !rst;
        if (rst) begin
            model_reset();
        end else begin
            q = val && h < 640 && v < 480;
            a = q ? (v / 2) * IMG_W + ((h / 2 + scroll) % IMG_W) : 0;
            e.idx = q ? int'(rom[a]) : BLANK;
            e.v   = q;
            e.hs  = hs;
            e.vs  = vs;
            p[2] = p[1];
            p[1] = p[0];
            p[0] = e;
            exp_rom = a;
`ifdef BG_SCROLL_EN
            if (val && h == 639 && v == 479)
                scroll = (scroll + stp) % IMG_W;
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        int exp_v;
        for (int i = 0; i < NPIX; i++) rom[i] = 7'($urandom);
        rom[641] = 7'h2A;

        rst_n           = 1'b0;
        bus.h_cnt       = '0;
        bus.v_cnt       = '0;
        bus.valid       = 1'b0;
        bus.hsync_in    = 1'b1;
        bus.vsync_in    = 1'b1;
        bus.scroll_step = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // Static image and blanking
        apply(3, 5, 1, 1, 1, 0, 0);
        chk("first_addr", 32'(bus.rom_addr), 32'd641);
        apply(700, 10, 0, 0, 1, 0, 0);
        chk("blank_addr", 32'(bus.rom_addr), 32'd0);
        apply(701, 10, 0, 1, 1, 0, 0);
        chk("first_idx", 32'(bus.pixel_idx), 32'h2A);
        chk("first_valid", 32'(bus.pixel_valid), 32'd1);
        apply(702, 10, 0, 1, 1, 0, 0);
        chk("blank_idx", 32'(bus.pixel_idx), 32'd6);
        chk("blank_valid", 32'(bus.pixel_valid), 32'd0);
        chk("blank_hsync", 32'(bus.hsync_out), 32'd0);

        // Scroll wrap: 22 end-of-frame points with step 15
        for (int i = 0; i < 22; i++) apply(639, 479, 1, 1, 1, 15, 0);
        apply(630, 0, 1, 1, 1, 15, 0);
`ifdef BG_SCROLL_EN
        exp_v = 5;
`else
        exp_v = 315;
`endif
        chk("wrap_addr", 32'(bus.rom_addr), 32'(exp_v));

        // Last-pixel rule after a reset
        apply(0, 0, 0, 1, 1, 0, 1);
        apply(639, 479, 1, 1, 1, 4, 0);
        chk("last_px_addr", 32'(bus.rom_addr), 32'd76799);
        apply(0, 0, 1, 1, 1, 7, 0);
`ifdef BG_SCROLL_EN
        exp_v = 4;
`else
        exp_v = 0;
`endif
        chk("next_frame_addr", 32'(bus.rom_addr), 32'(exp_v));

        // Mid-frame reset
        apply(198, 100, 1, 1, 1, 0, 0);
        apply(199, 100, 1, 1, 1, 0, 0);
        apply(200, 100, 1, 1, 1, 0, 1);
        chk("rst_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_valid", 32'(bus.pixel_valid), 32'd0);
        chk("rst_idx", 32'(bus.pixel_idx), 32'd6);
        apply(201, 100, 1, 1, 1, 0, 1);
        apply(202, 100, 1, 1, 1, 0, 0);
        chk("post_rst_addr", 32'(bus.rom_addr), 32'd16101);

        // Frame-to-frame scroll with step 15 over 3 frames
        apply(0, 0, 0, 1, 1, 0, 1);
        for (int f = 1; f <= 3; f++) begin
            apply(639, 479, 1, 1, 1, 15, 0);
            apply(0, 0, 1, 1, 1, 15, 0);
`ifdef BG_SCROLL_EN
            exp_v = 15 * f;
`else
            exp_v = 0;
`endif
            chk("frame_origin_addr", 32'(bus.rom_addr), 32'(exp_v));
        end

        // Randomized mix of active, blanking, out-of-range-valid and end-of-frame vectors
        for (int i = 0; i < 3000; i++) begin
            int r;
            int h;
            int v;
            bit val;
            r = $urandom_range(0, 19);
            if (r < 14) begin
                h = $urandom_range(0, 639); v = $urandom_range(0, 479); val = 1'b1;
            end else if (r < 16) begin
                h = $urandom_range(0, 799); v = $urandom_range(0, 524); val = 1'b0;
            end else if (r < 18) begin
                if ($urandom_range(0, 1) == 0) begin
                    h = $urandom_range(640, 799); v = $urandom_range(0, 524);
                end else begin
                    h = $urandom_range(0, 799); v = $urandom_range(480, 524);
                end
                val = 1'b1;
            end else begin
                h = 639; v = 479; val = 1'b1;
            end
            apply(h, v, val, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
                  $urandom_range(0, 299) == 0);
        end
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/bg_index_fetch.md
# bg_index_fetch

Upstream stage of the background palette decoder. Turns the VGA scan position into a background-image ROM address with 2x upscaling and optional per-frame horizontal scrolling. It captures the 7-bit palette index returned by the synchronous ROM and delivers it to the palette decoder with matching delayed sync and valid. The image is 320x240, shown at 640x480.

## Interface
Parameters:
- IMG_W, 320, source image width in pixels
- IMG_H, 240, source image height in lines
- ADDR_W, 17, ROM address width (IMG_W*IMG_H = 76800 fits)
- IDX_W, 7, palette index width
- BLANK_IDX, 6, index emitted outside the active area (decodes to black)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- h_cnt  in  10  horizontal scan position, 0..799
- v_cnt  in  10  vertical scan position, 0..524
- valid  in  1  high while (h_cnt, v_cnt) is in the 640x480 active area
- hsync_in  in  1  horizontal sync, active-low
- vsync_in  in  1  vertical sync, active-low
- scroll_step  in  4  pixels added to the scroll offset per frame
- rom_addr  out  ADDR_W  registered ROM read address
- rom_data  in  IDX_W  ROM read data, valid 1 cycle after rom_addr
- pixel_idx  out  IDX_W  palette index to the decoder
- pixel_valid  out  1  pixel_idx is an image pixel
- hsync_out  out  1  hsync_in delayed to align with pixel_idx
- vsync_out  out  1  vsync_in delayed to align with pixel_idx

## Operation
- Qualified valid: q = valid && h_cnt < 640 && v_cnt < 480. When valid is high with an out-of-range coordinate, the pixel is treated as q = 0.
- Source coordinates:
  - x_src = ((h_cnt >> 1) + scroll) mod IMG_W, computed with a single conditional subtract (sum < 2*IMG_W).
  - y_src = v_cnt >> 1.
- Address: y_src*IMG_W + x_src, computed as (y_src<<8) + (y_src<<6) + x_src. No multiplier.
- Stage 1: rom_addr <= q ? address : 0. q, hsync_in and vsync_in are registered into the stage-1 side pipe.
- Stage 2: the ROM returns rom_data. The side pipe advances.
- Stage 3: pixel_idx <= q_d2 ? rom_data : BLANK_IDX. pixel_valid <= q_d2. hsync_out and vsync_out are taken from the side pipe.
- scroll register, 9 bits:
  - Updates only on the cycle where valid is high, h_cnt = 639 and v_cnt = 479 (last active pixel).
  - Update rule: scroll <= (scroll + scroll_step) mod IMG_W, with a single conditional subtract.
  - The new value takes effect from the next frame's first pixel.
  - The pixel at (639,479) uses the old scroll.
- Reset (asynchronous, any time, including mid-frame):
  - rom_addr = 0, pixel_idx = BLANK_IDX, pixel_valid = 0, hsync_out = 1, vsync_out = 1.
  - Side pipe cleared to q = 0, syncs = 1. scroll = 0.
  - After release, the block resumes on the next rising edge with the current inputs. It does not wait for a frame boundary.

## Timing
- Latency is exactly 3 clk from (h_cnt, v_cnt, valid, syncs) to (pixel_idx, pixel_valid, hsync_out, vsync_out).
- One pixel per clock, no stalls, no backpressure.
- rom_addr is launched 1 cycle after the inputs. rom_data is sampled 2 cycles after the inputs.
- Sync and valid stay cycle-aligned with pixel_idx at all times, including the first 3 cycles after reset (those cycles show the reset values).
- scroll_step is sampled only in the update cycle; changes at other times have no effect.
- A scroll change can never split a frame.

## Configuration
- BG_SCROLL_EN:
  - Defined: scroll register and per-frame update behave as described.
  - Not defined: no scroll register is synthesised, scroll is constant 0, scroll_step is ignored, and x_src = h_cnt >> 1.
- Latency is 3 cycles in both builds.

## Test plan
- Reset then static image, scroll 0:
  - h=3, v=5, valid=1 -> rom_addr = 641 one cycle later.
  - With rom_data=0x2A returned -> pixel_idx = 0x2A and pixel_valid = 1 three cycles after the inputs.
- Blanking: h=700, v=10, valid=0, hsync_in=0 -> rom_addr = 0; 3 cycles later pixel_idx = 6, pixel_valid = 0, hsync_out = 0.
- Wrap on address: scroll_step=15.
  - Drive the end-of-frame point (639,479) 22 times -> scroll = 330 mod 320 = 10.
  - Then h=630, v=0 -> x_src = (315+10)-320 = 5, rom_addr = 5.
- Last-pixel rule: with scroll=0, step=4, drive (639,479) -> that pixel's rom_addr = 239*320 + 319 = 76799; next frame (0,0) -> rom_addr = 4.
- Reset mid-frame: after a frame with step=4 (scroll=4), assert rst_n low at (200,100) for 2 cycles.
  - During reset: outputs at reset values.
  - Next valid pixel (202,100) -> rom_addr = 50*320 + 101 = 16101 (scroll back to 0).
- Build without BG_SCROLL_EN: step=15 over 3 frames; (0,0) -> rom_addr = 0 every frame.
